// File: rtl/alu_mc_if.sv
// Issue/result bundle for alu_mc: the pipeline (master) issues ops and receives
// results, the ALU (slave) accepts ops and drives results and the HI/LO registers.
interface alu_mc_if #(
    parameter int WIDTH = 32
) ();
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_control;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, a, b, alu_control, shamt,
        input  in_ready, out_valid, result, zero, hi, lo
    );

    modport slave (
        input  in_valid, a, b, alu_control, shamt,
        output in_ready, out_valid, result, zero, hi, lo
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle MIPS execute ALU: registered single-cycle ops, iterative MULTU/DIVU into HI/LO.
// Define ALU_DIV_EN to compile in the restoring divider; otherwise DIVU is an illegal opcode.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mc_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST_CNT = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLL   = 4'b0011;
    localparam logic [3:0] OP_SRL   = 4'b0100;
    localparam logic [3:0] OP_SRA   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
`ifdef ALU_DIV_EN
    localparam logic [3:0] OP_DIVU  = 4'b1010;
`endif
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MFHI  = 4'b1101;
    localparam logic [3:0] OP_MFLO  = 4'b1110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef ALU_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_MUL  = 2'd1
    } state_e;

    state_e           r_state;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_out_valid;

    logic             w_idle;
    logic             w_issue;
    logic             w_is_mul;
    logic             w_last;
    logic [WIDTH-1:0] w_alu_result;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;
`ifdef ALU_DIV_EN
    logic             w_is_div;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;

    assign w_is_div = (bus.alu_control == OP_DIVU);
`endif

    assign w_idle   = (r_state == S_IDLE);
    assign w_issue  = bus.in_valid && w_idle;
    assign w_is_mul = (bus.alu_control == OP_MULTU);
    assign w_last   = (r_cnt == LAST_CNT);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_alu_result = '0;
        case (bus.alu_control)
            OP_AND:  w_alu_result = bus.a & bus.b;
            OP_OR:   w_alu_result = bus.a | bus.b;
            OP_ADD:  w_alu_result = bus.a + bus.b;
            OP_SLL:  w_alu_result = bus.b << bus.shamt;
            OP_SRL:  w_alu_result = bus.b >> bus.shamt;
            OP_SRA:  w_alu_result = $signed(bus.b) >>> bus.shamt;
            OP_SUB:  w_alu_result = bus.a - bus.b;
            OP_SLT:  w_alu_result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: w_alu_result = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_NOR:  w_alu_result = ~(bus.a | bus.b);
            OP_MFHI: w_alu_result = r_hi;
            OP_MFLO: w_alu_result = r_lo;
            default: w_alu_result = '0;
        endcase
    end

    // One iteration of either engine; {acc_hi, acc_lo} ends as {hi, lo} for both ops.
    always_comb begin
        w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
        w_step_hi = w_mul_sum[WIDTH:1];
        w_step_lo = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opnd};
        if (r_state == S_DIV) begin
            // A zero divisor never borrows, so the quotient saturates to all ones and rem = a.
            if (!w_div_diff[WIDTH]) begin
                w_step_hi = w_div_diff[WIDTH-1:0];
                w_step_lo = {r_acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_step_hi = w_div_shift[WIDTH-1:0];
                w_step_lo = {r_acc_lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc_hi    <= '0;
            r_acc_lo    <= '0;
            r_opnd      <= '0;
            r_result    <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_idle) begin
                if (w_issue) begin
                    if (w_is_mul) begin
                        r_state  <= S_MUL;
                        r_acc_hi <= '0;
                        r_acc_lo <= bus.b;
                        r_opnd   <= bus.a;
                        r_cnt    <= '0;
                    end
`ifdef ALU_DIV_EN
                    else if (w_is_div) begin
                        r_state  <= S_DIV;
                        r_acc_hi <= '0;
                        r_acc_lo <= bus.a;
                        r_opnd   <= bus.b;
                        r_cnt    <= '0;
                    end
`endif
                    else begin
                        r_result    <= w_alu_result;
                        r_out_valid <= 1'b1;
                    end
                end
            end else begin
                r_acc_hi <= w_step_hi;
                r_acc_lo <= w_step_lo;
                r_cnt    <= r_cnt + SHW'(1);
                if (w_last) begin
                    r_hi        <= w_step_hi;
                    r_lo        <= w_step_lo;
                    r_result    <= w_step_lo;
                    r_out_valid <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= S_IDLE;
                end
            end
        end
    end

    assign bus.in_ready  = w_idle;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = (r_result == '0);
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vectors, a behavioural model scoreboard,
// and literal expectations for the headline vectors.
module tb_alu_mc;
    localparam int W   = 32;
    localparam int SHW = $clog2(W);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLL   = 4'b0011;
    localparam logic [3:0] OP_SRL   = 4'b0100;
    localparam logic [3:0] OP_SRA   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_ILL   = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MFHI  = 4'b1101;
    localparam logic [3:0] OP_MFLO  = 4'b1110;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int           due;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    exp_t         q[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    int           busy_start = 0;
    int           busy_until = 0;
    logic [W-1:0] last_res = '0;
    logic [W-1:0] last_hi  = '0;
    logic [W-1:0] last_lo  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] model_single(input logic [3:0] op, input logic [W-1:0] a,
                                                  input logic [W-1:0] b, input logic [SHW-1:0] sh);
        logic [2*W-1:0] ext;
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_NOR:  return ~(a | b);
            OP_SLL:  begin ext = {{W{1'b0}}, b} << sh; return ext[W-1:0]; end
            OP_SRL:  begin ext = {{W{1'b0}}, b} >> sh; return ext[W-1:0]; end
            OP_SRA:  begin ext = {{W{b[W-1]}}, b} >> sh; return ext[W-1:0]; end
            OP_SLT:  return (int'($signed(a)) < int'($signed(b))) ? W'(1) : W'(0);
            OP_SLTU: return (longint'(a) < longint'(b)) ? W'(1) : W'(0);
            OP_MFHI: return m_hi;
            OP_MFLO: return m_lo;
            default: return '0;
        endcase
    endfunction

    // Present an op at a negedge, hold it until accepted, record the expected outcome.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [SHW-1:0] sh);
        int             guard;
        int             n;
        bit             long_op;
        exp_t           e;
        logic [2*W-1:0] prod;
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.alu_control = op;
        bus.a           = a;
        bus.b           = b;
        bus.shamt       = sh;
        guard = 0;
        while (!bus.in_ready) begin
            if (guard == 200) begin
                check("issue_timeout", 0, 1);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            guard++;
        end
        n       = cyc + 1;
        long_op = 1'b0;
        e.res   = model_single(op, a, b, sh);
        if (op == OP_MULTU) begin
            prod    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            m_hi    = prod[2*W-1:W];
            m_lo    = prod[W-1:0];
            e.res   = m_lo;
            long_op = 1'b1;
        end
`ifdef ALU_DIV_EN
        else if (op == OP_DIVU) begin
            if (b == 0) begin
                m_lo = '1;
                m_hi = a;
            end else begin
                m_lo = a / b;
                m_hi = a % b;
            end
            e.res   = m_lo;
            long_op = 1'b1;
        end
`endif
        if (long_op) begin
            busy_start = n;
            busy_until = n + W;
        end
        e.due = long_op ? n + W : n;
        e.hi  = m_hi;
        e.lo  = m_lo;
        q.push_back(e);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() != 0) begin
            check("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    // Compare process: handshake and result pulses checked against the model every cycle.
    always @(negedge clk) begin
        exp_t e;
        logic exp_ready;
        if (!rst_n) begin
            check("reset_out_valid", bus.out_valid, 0);
            check("reset_in_ready", bus.in_ready, 1);
        end else begin
            exp_ready = !(cyc >= busy_start && cyc < busy_until);
            check("in_ready", bus.in_ready, exp_ready);
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("out_valid_cycle", cyc, e.due);
                    check("result", bus.result, e.res);
                    check("zero", bus.zero, (e.res == 0));
                    check("hi", bus.hi, e.hi);
                    check("lo", bus.lo, e.lo);
                    last_res = bus.result;
                    last_hi  = bus.hi;
                    last_lo  = bus.lo;
                end
            end else if (q.size() != 0 && q[0].due < cyc) begin
                check("missing_out_valid", cyc, q[0].due);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.alu_control = '0;
        bus.shamt       = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_result", bus.result, 0);
        check("rst_zero", bus.zero, 1);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);

        issue(OP_ADD, 32'd4, 32'd1, '0);
        drain();
        check("add_result", last_res, 32'd5);
        check("add_zero", bus.zero, 0);
        issue(OP_SUB, 32'd4, 32'd4, '0);
        drain();
        check("sub_result", last_res, 32'd0);
        check("sub_zero", bus.zero, 1);

        // Back-to-back single-cycle issue.
        issue(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, '0);
        issue(OP_OR,  32'hF000_0001, 32'h0000_1000, '0);
        issue(OP_NOR, 32'h0F0F_0F0F, 32'h3000_0000, '0);
        issue(OP_SRL, 32'd0, 32'h8000_0010, 5'd4);
        issue(OP_SUB, 32'd0, 32'd1, '0);
        drain();
        check("sub_wrap", last_res, 32'hFFFF_FFFF);

        issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, '0);
        drain();
        check("slt", last_res, 32'd1);
        issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1, '0);
        drain();
        check("sltu", last_res, 32'd0);
        issue(OP_SRA, 32'd0, 32'h8000_0000, 5'd4);
        drain();
        check("sra", last_res, 32'hF800_0000);
        issue(OP_SLL, 32'd0, 32'd1, 5'd31);
        drain();
        check("sll", last_res, 32'h8000_0000);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, '0);
        drain();
        check("mul_result", last_res, 32'hFFFF_FFFE);
        check("mul_hi", last_hi, 32'h0000_0001);
        check("mul_lo", last_lo, 32'hFFFF_FFFE);
        issue(OP_MFHI, '0, '0, '0);
        drain();
        check("mfhi", last_res, 32'd1);
        issue(OP_MFLO, '0, '0, '0);
        drain();
        check("mflo", last_res, 32'hFFFF_FFFE);

        issue(OP_DIVU, 32'd7, 32'd2, '0);
        drain();
`ifdef ALU_DIV_EN
        check("div_result", last_res, 32'd3);
        check("div_hi", last_hi, 32'd1);
        check("div_lo", last_lo, 32'd3);
`else
        check("divu_illegal_result", last_res, 32'd0);
        check("divu_illegal_hi", last_hi, 32'd1);
        check("divu_illegal_lo", last_lo, 32'hFFFF_FFFE);
`endif
        issue(OP_DIVU, 32'd9, 32'd0, '0);
        drain();
`ifdef ALU_DIV_EN
        check("div0_lo", last_lo, 32'hFFFF_FFFF);
        check("div0_hi", last_hi, 32'd9);
`else
        check("div0_illegal_result", last_res, 32'd0);
        check("div0_illegal_hi", last_hi, 32'd1);
`endif

        issue(OP_MFLO, '0, '0, '0);
        issue(OP_ILL, 32'd5, 32'd6, '0);
        drain();
        check("illegal_result", last_res, 32'd0);
        check("illegal_zero", bus.zero, 1);
        issue(4'b1111, 32'd5, 32'd6, '0);
        drain();

        // ADD held pending behind a multiply; it must be accepted exactly once.
        issue(OP_MULTU, 32'd3, 32'd5, '0);
        issue(OP_ADD, 32'd10, 32'd20, '0);
        drain();
        check("held_add", last_res, 32'd30);
        check("held_add_lo", last_lo, 32'd15);
        check("held_add_hi", last_hi, 32'd0);

        // Reset in the middle of a multiply aborts it without a result pulse.
        issue(OP_MULTU, 32'h0000_1234, 32'h0000_0010, '0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        m_hi       = '0;
        m_lo       = '0;
        busy_start = 0;
        busy_until = 0;
        @(negedge clk);
        check("abort_result", bus.result, 0);
        check("abort_hi", bus.hi, 0);
        check("abort_lo", bus.lo, 0);
        check("abort_zero", bus.zero, 1);
        #2 rst_n = 1'b1;
        repeat (W + 5) @(negedge clk);
        check("post_abort_hi", bus.hi, 0);
        check("post_abort_result", bus.result, 0);

        issue(OP_ADD, 32'd1, 32'd2, '0);
        drain();
        check("recover_add", last_res, 32'd3);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
